// File: rtl/gameover_banner.sv
// gameover_banner: slides the game-over sprite down from the top, holds it, then blinks it,
// compositing it over the background with a one-clock registered pixel output.
module gameover_banner #(
    parameter int IMG_W        = 256,
    parameter int IMG_H        = 32,
    parameter int X_POS        = 192,
    parameter int Y_FINAL      = 224,
    parameter int SLIDE_STEP   = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       game_over,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       video_on,
    input  logic [7:0] bg_r,
    input  logic [7:0] bg_g,
    input  logic [7:0] bg_b,
    output logic [9:0] img_x,
    output logic [9:0] img_y,
    input  logic [7:0] img_r,
    input  logic [7:0] img_g,
    input  logic [7:0] img_b,
    input  logic       img_a,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic       out_video_on,
    output logic       banner_active
);
    localparam int CW = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, SLIDE, HOLD, BLINK} state_t;

    state_t        state;
    logic [9:0]    y_pos;
    logic [CW-1:0] cnt;
    logic          visible;
    logic          hit;

    // 11-bit compares so the right/bottom edges never wrap
    always_comb begin
        hit = visible
            && {1'b0, hcount} >= 11'(X_POS) && {1'b0, hcount} < 11'(X_POS + IMG_W)
            && vcount >= y_pos && {1'b0, vcount} < {1'b0, y_pos} + 11'(IMG_H);
        img_x = hit ? hcount - 10'(X_POS) : '0;
        img_y = hit ? vcount - y_pos : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            y_pos         <= '0;
            cnt           <= '0;
            visible       <= 1'b0;
            banner_active <= 1'b0;
            out_r         <= '0;
            out_g         <= '0;
            out_b         <= '0;
            out_video_on  <= 1'b0;
        end else begin
            out_video_on <= video_on;
            {out_r, out_g, out_b} <= !video_on ? 24'h0 :
                                     (hit && img_a) ? {img_r, img_g, img_b} : {bg_r, bg_g, bg_b};
            // all animation state moves only on frame_start to avoid mid-frame tearing
            if (frame_start) begin
                if (state != IDLE && !game_over) begin
                    state         <= IDLE;
                    y_pos         <= '0;
                    cnt           <= '0;
                    visible       <= 1'b0;
                    banner_active <= 1'b0;
                end else begin
                    case (state)
                        IDLE: if (game_over) begin
                            state         <= SLIDE;
                            visible       <= 1'b1;
                            banner_active <= 1'b1;
                        end
                        SLIDE: if ({1'b0, y_pos} + 11'(SLIDE_STEP) >= 11'(Y_FINAL)) begin
                            y_pos <= 10'(Y_FINAL);
                            cnt   <= '0;
                            state <= HOLD;
                        end else begin
                            y_pos <= y_pos + 10'(SLIDE_STEP);
                        end
                        HOLD: if (cnt == CW'(BLINK_FRAMES - 1)) begin
                            cnt   <= '0;
                            state <= BLINK;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                        BLINK: if (cnt == CW'(BLINK_FRAMES - 1)) begin
                            cnt     <= '0;
                            visible <= !visible;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/gameover_banner.md
# gameover_banner

Positions and animates the 256x32 one-bit "game over" sprite on the 640x480 VGA raster and composites it over the game background. The block sits between the VGA timing/background path and the sprite ROM. It converts screen coordinates to sprite-local coordinates for the ROM, takes back RGBA, and drives the final registered pixel to the VGA output stage. The banner slides down from the top edge, holds, then blinks until the game leaves the game-over state.

## Interface
- IMG_W, 256, sprite width in pixels
- IMG_H, 32, sprite height in pixels
- X_POS, 192, fixed left edge of banner (centred on 640)
- Y_FINAL, 224, resting top edge of banner
- SLIDE_STEP, 4, pixels moved per frame during slide
- BLINK_FRAMES, 30, frames per hold period and per blink half-period

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse once per frame, during vertical blank
- game_over  in  1  level; high while game is in game-over state
- hcount  in  10  current pixel column
- vcount  in  10  current pixel row
- video_on  in  1  high in active display area
- bg_r, bg_g, bg_b  in  8 each  background pixel for (hcount, vcount)
- img_x  out  10  sprite-local column to sprite ROM (combinational)
- img_y  out  10  sprite-local row to sprite ROM (combinational)
- img_r, img_g, img_b  in  8 each  sprite colour returned for (img_x, img_y), same cycle
- img_a  in  1  sprite opacity, same cycle
- out_r, out_g, out_b  out  8 each  composited pixel, registered
- out_video_on  out  1  video_on delayed to align with out_*
- banner_active  out  1  high in any state except IDLE, registered

## Operation
- State machine: IDLE, SLIDE, HOLD, BLINK. All state, y_pos, frame counter and visible flag update only on cycles with frame_start=1. This guarantees no mid-frame tearing.
- IDLE: y_pos=0, visible=0. On frame_start with game_over=1, go to SLIDE and set visible=1.
- SLIDE: on each frame_start, if y_pos+SLIDE_STEP >= Y_FINAL, set y_pos=Y_FINAL, clear counter and go to HOLD. Otherwise y_pos += SLIDE_STEP.
- HOLD: on each frame_start, counter increments. When counter reaches BLINK_FRAMES-1, clear it and go to BLINK with visible still 1.
- BLINK: on each frame_start, counter increments. At BLINK_FRAMES-1, clear counter and toggle visible.
- In any non-IDLE state, frame_start with game_over=0 forces IDLE, y_pos=0, visible=0, counter=0. Exit takes priority over every other transition on the same frame_start.
- game_over changes between frame_start pulses have no effect until the next pulse.
- Hit test is combinational. The test is hit = visible and X_POS <= hcount < X_POS+IMG_W and y_pos <= vcount < y_pos+IMG_H. The comparisons use 11-bit sums, so no wrap occurs.
- img_x = hcount-X_POS and img_y = vcount-y_pos when hit is set. Otherwise both are 0.
- Composite: if video_on=0, the pixel is 0. Else if hit and img_a, the pixel is img_rgb. Otherwise it is bg_rgb.

## Timing
- Reset (async assert, sync-safe deassert by clk): state=IDLE, y_pos=0, counter=0, visible=0. out_r/g/b=0, out_video_on=0, banner_active=0.
- img_x/img_y are combinational from hcount/vcount and registered state. The sprite ROM returns data in the same cycle.
- out_* and out_video_on lag hcount/vcount/bg/video_on by exactly 1 clk.
- banner_active updates 1 clk after the frame_start that changes state.
- The first visible frame has its top edge at row 0, on the frame after the entering frame_start. From IDLE, Y_FINAL is reached after ceil(Y_FINAL/SLIDE_STEP) frame_starts in SLIDE, which is 56 with the defaults.
- Reset mid-slide or mid-blink returns to IDLE immediately; the next banner restarts from y_pos=0.

## Test plan
- Reset, then game_over=1 and one frame_start -> banner_active=1 next clk. Pixel (192,0) with img_a=1, img_rgb=FFFFFF gives out FFFFFF 1 clk later. Pixel (191,0) gives bg.
- Hold game_over=1 for 56 frame_starts -> y_pos=224 and state HOLD. Row 223 shows bg, rows 224..255 show the sprite, and img_y=0 at vcount=224.
- Continue 30 more frame_starts -> BLINK with banner still visible. Send 30 more -> banner hidden, (300,230) shows bg even with img_a=1. Send 30 more -> visible again.
- Drop game_over mid-slide, then give a frame_start -> IDLE, out=bg everywhere, banner_active=0. Raising game_over again restarts from y_pos=0.
- video_on=0 with a hit and img_a=1 -> out_rgb=0 and out_video_on=0 one clk later. Pulse rst_n low mid-BLINK -> all outputs 0 asynchronously.
